// File: rtl/tick_pwm.sv
// Tick-paced PWM generator: period and duty are counted in time-base ticks, with
// shadowed settings applied at period wraps and a disable that finishes the period.
module tick_pwm #(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             enable,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] period_in,
   input  logic [WIDTH-1:0] duty_in,
   output logic             pwm_out,
   output logic             cycle_done,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] per_act_q, per_act_d;
   logic [WIDTH-1:0] duty_act_q, duty_act_d;
   logic [WIDTH-1:0] per_sh_q, per_sh_d;
   logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
   logic             pending_q, pending_d;
   logic             cycle_done_q, cycle_done_d;
   logic             wrap;

   assign wrap = (state_q != IDLE) && tick && (cnt_q == per_act_q);

   always_comb begin
      // NOTE: every target gets a default first, so no path leaves a latch behind.
      state_d      = state_q;
      cnt_d        = cnt_q;
      per_act_d    = per_act_q;
      duty_act_d   = duty_act_q;
      per_sh_d     = per_sh_q;
      duty_sh_d    = duty_sh_q;
      pending_d    = pending_q;
      cycle_done_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable) begin
               state_d    = RUN;
               per_act_d  = per_sh_q;
               duty_act_d = duty_sh_q;
               pending_d  = 1'b0;
            end
         end
         RUN, STOP: begin
            if (tick) begin
               if (wrap) begin
                  cnt_d        = '0;
                  cycle_done_d = 1'b1;
                  if (pending_q) begin
                     per_act_d  = per_sh_q;
                     duty_act_d = duty_sh_q;
                     pending_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            // A re-raised enable in STOP wins over the wrap, so the block keeps running.
            if (state_q == RUN) begin
               if (!enable) state_d = STOP;
            end else if (enable) begin
               state_d = RUN;
            end else if (wrap) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Load is applied last: a value captured on a wrap edge stays pending for the next one.
      if (load) begin
         per_sh_d  = period_in;
         duty_sh_d = duty_in;
         pending_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         per_act_q    <= '0;
         duty_act_q   <= '0;
         per_sh_q     <= '0;
         duty_sh_q    <= '0;
         pending_q    <= 1'b0;
         cycle_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         per_act_q    <= per_act_d;
         duty_act_q   <= duty_act_d;
         per_sh_q     <= per_sh_d;
         duty_sh_q    <= duty_sh_d;
         pending_q    <= pending_d;
         cycle_done_q <= cycle_done_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign pwm_out    = busy && (cnt_q < duty_act_q);
   assign cycle_done = cycle_done_q;

endmodule
